// File: rtl/fetch_queue.sv
// Instruction-fetch stage: one outstanding imem read, results buffered in a
// small circular FIFO and handed to decode over valid/ready; br_taken flushes.
module fetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  program_index,
  input  logic               br_taken,
  output logic               pc_advance,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t             state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic push;
  logic pop;

  assign push       = (state_q == S_WAIT) && imem_ack && !br_taken;
  assign pop        = id_valid && id_ready;
  assign pc_advance = push;
  assign id_valid   = (count_q != '0);
  assign id_instr   = instr_mem[head_q];
  assign id_pc      = pc_mem[head_q];
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;

  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    unique case (state_q)
      S_IDLE: begin
        // Space is checked here so a later push from WAIT always fits.
        if ((count_q < CNT_W'(DEPTH)) && !br_taken) begin
          state_d     = S_WAIT;
          imem_addr_d = program_index;
        end
      end
      S_WAIT: begin
        if (imem_ack)      state_d = S_IDLE;
        else if (br_taken) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d = (state_d != S_IDLE);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (br_taken) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= imem_data;
      pc_mem[tail_q]    <= imem_addr_q;
    end
  end

endmodule
